// File: rtl/qspi_master.sv
// qspi_master: quad-SPI initiator, SPI mode 0, two QCK cycles per byte, high nibble first.
// Define QSPI_MASTER_DUMMY_EN to add io_cmd_dummy (read dummy QCK cycles before data).
module qspi_master #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8
) (
    input  logic             io_mainClk,
    input  logic             io_asyncReset,
    input  logic             io_cmd_valid,
    output logic             io_cmd_ready,
    input  logic             io_cmd_write,
    input  logic [LEN_W-1:0] io_cmd_length,
`ifdef QSPI_MASTER_DUMMY_EN
    input  logic [3:0]       io_cmd_dummy,
`endif
    input  logic             io_tx_valid,
    output logic             io_tx_ready,
    input  logic [7:0]       io_tx_data,
    output logic             io_rx_valid,
    output logic [7:0]       io_rx_data,
    output logic             io_busy,
    output logic             io_qspi_qss,
    output logic             io_qspi_qck,
    input  logic [3:0]       io_qspi_qd_read,
    output logic [3:0]       io_qspi_qd_write,
    output logic [3:0]       io_qspi_qd_writeEnable
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_FETCH, S_SHIFT, S_HOLD, S_GAP, S_DUMMY
    } state_t;

    state_t           r_state, w_state;
    logic [DW-1:0]    r_div, w_div;
    logic [1:0]       r_ph, w_ph;
    logic [LEN_W-1:0] r_len, w_len;
    logic             r_wr, w_wr;
    logic [7:0]       r_sh, w_sh;
    logic             r_qss, w_qss;
    logic             r_qck, w_qck;
    logic [3:0]       r_qd, w_qd;
    logic             r_oe, w_oe;
    logic             r_tx_ready, w_tx_ready;
    logic             r_rx_valid, w_rx_valid;
    logic [7:0]       r_rx_data, w_rx_data;
    logic             r_busy, w_busy;
    logic             r_cmd_ready, w_cmd_ready;
    logic             w_tick;
`ifdef QSPI_MASTER_DUMMY_EN
    logic [3:0]       r_dcnt, w_dcnt;
`endif

    assign w_tick = (r_div == DW'(CLK_DIV - 1));

    assign io_cmd_ready           = r_cmd_ready;
    assign io_tx_ready            = r_tx_ready;
    assign io_rx_valid            = r_rx_valid;
    assign io_rx_data             = r_rx_data;
    assign io_busy                = r_busy;
    assign io_qspi_qss            = r_qss;
    assign io_qspi_qck            = r_qck;
    assign io_qspi_qd_write       = r_qd;
    assign io_qspi_qd_writeEnable = {4{r_oe}};

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_ph        <= 2'd0;
            r_len       <= '0;
            r_wr        <= 1'b0;
            r_sh        <= 8'h00;
            r_qss       <= 1'b1;
            r_qck       <= 1'b0;
            r_qd        <= 4'h0;
            r_oe        <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
`ifdef QSPI_MASTER_DUMMY_EN
            r_dcnt      <= 4'd0;
`endif
        end else begin
            r_state     <= w_state;
            r_div       <= w_div;
            r_ph        <= w_ph;
            r_len       <= w_len;
            r_wr        <= w_wr;
            r_sh        <= w_sh;
            r_qss       <= w_qss;
            r_qck       <= w_qck;
            r_qd        <= w_qd;
            r_oe        <= w_oe;
            r_tx_ready  <= w_tx_ready;
            r_rx_valid  <= w_rx_valid;
            r_rx_data   <= w_rx_data;
            r_busy      <= w_busy;
            r_cmd_ready <= w_cmd_ready;
`ifdef QSPI_MASTER_DUMMY_EN
            r_dcnt      <= w_dcnt;
`endif
        end
    end

    // Next-state and next-output decode; the divider restarts on every tick and state change
    always_comb begin
        w_state     = r_state;
        w_div       = r_div + DW'(1);
        w_ph        = r_ph;
        w_len       = r_len;
        w_wr        = r_wr;
        w_sh        = r_sh;
        w_qss       = r_qss;
        w_qck       = r_qck;
        w_qd        = r_qd;
        w_oe        = r_oe;
        w_tx_ready  = r_tx_ready;
        w_rx_valid  = 1'b0;
        w_rx_data   = r_rx_data;
        w_busy      = r_busy;
        w_cmd_ready = r_cmd_ready;
`ifdef QSPI_MASTER_DUMMY_EN
        w_dcnt      = r_dcnt;
`endif
        unique case (r_state)
            S_IDLE: begin
                w_div = '0;
                if (io_cmd_valid) begin
                    w_state     = S_SETUP;
                    w_qss       = 1'b0;
                    w_busy      = 1'b1;
                    w_cmd_ready = 1'b0;
                    w_wr        = io_cmd_write;
                    w_len       = io_cmd_length;
`ifdef QSPI_MASTER_DUMMY_EN
                    w_dcnt      = io_cmd_write ? 4'd0 : io_cmd_dummy;
`endif
                end
            end
            S_SETUP: begin
                if (w_tick) begin
                    w_div = '0;
                    w_ph  = 2'd0;
                    if (r_wr) begin
                        w_state    = S_FETCH;
                        w_tx_ready = 1'b1;
                    end else begin
                        w_state = S_SHIFT;
`ifdef QSPI_MASTER_DUMMY_EN
                        if (r_dcnt != 4'd0) w_state = S_DUMMY;
`endif
                    end
                end
            end
            S_FETCH: begin
                w_div = '0;
                if (io_tx_valid && r_tx_ready) begin
                    w_state    = S_SHIFT;
                    w_ph       = 2'd0;
                    w_tx_ready = 1'b0;
                    w_sh       = io_tx_data;
                    w_qd       = io_tx_data[7:4];
                    w_oe       = 1'b1;
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    w_div = '0;
                    w_ph  = r_ph + 2'd1;
                    case (r_ph)
                        2'd0: begin
                            w_qck = 1'b1;
                            if (!r_wr) w_sh[7:4] = io_qspi_qd_read;
                        end
                        2'd1: begin
                            w_qck = 1'b0;
                            if (r_wr) w_qd = r_sh[3:0];
                        end
                        2'd2: begin
                            w_qck = 1'b1;
                            if (!r_wr) w_sh[3:0] = io_qspi_qd_read;
                        end
                        default: begin
                            w_qck = 1'b0;
                            if (!r_wr) begin
                                w_rx_valid = 1'b1;
                                w_rx_data  = r_sh;
                            end
                            if (r_len == '0) begin
                                w_state = S_HOLD;
                            end else begin
                                w_len = r_len - LEN_W'(1);
                                if (r_wr) begin
                                    w_state    = S_FETCH;
                                    w_tx_ready = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            S_HOLD: begin
                if (w_tick) begin
                    w_div   = '0;
                    w_state = S_GAP;
                    w_qss   = 1'b1;
                    w_oe    = 1'b0;
                    w_qd    = 4'h0;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_div       = '0;
                    w_state     = S_IDLE;
                    w_busy      = 1'b0;
                    w_cmd_ready = 1'b1;
                end
            end
`ifdef QSPI_MASTER_DUMMY_EN
            S_DUMMY: begin
                if (w_tick) begin
                    w_div = '0;
                    if (!r_ph[0]) begin
                        w_qck = 1'b1;
                        w_ph  = 2'd1;
                    end else begin
                        w_qck = 1'b0;
                        w_ph  = 2'd0;
                        if (r_dcnt == 4'd1) w_state = S_SHIFT;
                        w_dcnt = r_dcnt - 4'd1;
                    end
                end
            end
`endif
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qspi_master.sv
// tb_qspi_master: random and directed transactions against a byte/nibble-level
// reference of the QSPI link, with a slave model and link monitor.
module tb_qspi_master;

    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 8;
    localparam int LOGN    = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_length = 8'h00;
`ifdef QSPI_MASTER_DUMMY_EN
    logic [3:0] cmd_dummy = 4'h0;
`endif
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       qss;
    logic       qck;
    logic [3:0] qd_read;
    logic [3:0] qd_write;
    logic [3:0] qd_oe;

    always #5 clk = ~clk;

    qspi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .io_mainClk             (clk),
        .io_asyncReset          (rst),
        .io_cmd_valid           (cmd_valid),
        .io_cmd_ready           (cmd_ready),
        .io_cmd_write           (cmd_write),
        .io_cmd_length          (cmd_length),
`ifdef QSPI_MASTER_DUMMY_EN
        .io_cmd_dummy           (cmd_dummy),
`endif
        .io_tx_valid            (tx_valid),
        .io_tx_ready            (tx_ready),
        .io_tx_data             (tx_data),
        .io_rx_valid            (rx_valid),
        .io_rx_data             (rx_data),
        .io_busy                (busy),
        .io_qspi_qss            (qss),
        .io_qspi_qck            (qck),
        .io_qspi_qd_read        (qd_read),
        .io_qspi_qd_write       (qd_write),
        .io_qspi_qd_writeEnable (qd_oe)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-side source: a byte stream consumed one byte per handshake
    logic [7:0] tx_mem [LOGN];
    int tx_cnt    = 0;
    int tx_avail  = 0;
    int stall_idx = -1;
    int stall_cnt = 0;
    logic stalling;

    always_comb begin
        stalling = (tx_cnt == stall_idx) && (stall_cnt < 20);
        tx_valid = (tx_cnt < tx_avail) && !stalling;
        tx_data  = tx_mem[tx_cnt % LOGN];
    end

    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_cnt <= tx_cnt + 1;
        if (stalling) stall_cnt <= stall_cnt + 1;
    end

    // Read-side slave: presents nibbles in order, counted by QCK rises since select
    logic [7:0] rd_mem [LOGN];
    int rd_base   = 0;
    int cur_dummy = 0;
    int s_rises   = 0;

    always @(posedge qck or posedge qss) begin
        if (qss) s_rises <= 0;
        else     s_rises <= s_rises + 1;
    end

    always_comb begin
        int idx;
        logic [7:0] b;
        idx = s_rises - cur_dummy;
        b   = 8'h00;
        qd_read = 4'hF;
        if (idx >= 0) begin
            b = rd_mem[(rd_base + idx / 2) % LOGN];
            qd_read = idx[0] ? b[3:0] : b[7:4];
        end
    end

    // Link monitor: logs rises, rx bytes, select windows and protocol violations
    int cyc = 0;
    logic prev_qck = 1'b0;
    logic prev_qss = 1'b1;
    logic cur_wr = 1'b0;
    int n_rise = 0, n_qfall = 0, n_rx = 0, n_oe_bad = 0;
    int st_cyc = 0, st_bad = 0, qfall_t = 0;
    logic [7:0] rise_log [LOGN];
    int         rise_t   [LOGN];
    logic [7:0] rx_log   [LOGN];

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        prev_qck <= qck;
        prev_qss <= qss;
        if (!rst) begin
            if (qck && !prev_qck) begin
                rise_log[n_rise % LOGN] <= {qd_oe, qd_write};
                rise_t[n_rise % LOGN]   <= cyc;
                n_rise <= n_rise + 1;
            end
            if (!qss && prev_qss) begin
                n_qfall <= n_qfall + 1;
                qfall_t <= cyc;
            end
            if (rx_valid) begin
                rx_log[n_rx % LOGN] <= rx_data;
                n_rx <= n_rx + 1;
            end
            if (qd_oe != 4'h0 && (qss || !cur_wr)) n_oe_bad <= n_oe_bad + 1;
            if (stalling && tx_ready) begin
                st_cyc <= st_cyc + 1;
                if (qck || !qss || qss) begin
                    if (qck || qss) st_bad <= st_bad + 1;
                end
            end
        end
    end

    function automatic logic [21:0] rst_vec();
        return {qss, qck, busy, cmd_ready, tx_ready, rx_valid, qd_write, qd_oe, rx_data};
    endfunction

    localparam logic [21:0] RST_EXP = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00};

    task automatic issue(input logic wr, input int len, input int dmy);
        for (int c = 0; c < 100 && !cmd_ready; c++) @(negedge clk);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_write  = wr;
        cmd_length = 8'(len);
`ifdef QSPI_MASTER_DUMMY_EN
        cmd_dummy  = 4'(dmy);
`endif
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'($urandom);
        cmd_length = 8'($urandom);
        chk("busy_on_accept", {31'd0, busy}, 32'd1);
        chk("qss_on_accept", {31'd0, qss}, 32'd0);
    endtask

    task automatic prep(input logic wr, input int len, input int dmy, input int b0, input int b1, input int stall_at);
        int nb;
        nb = len + 1;
        cur_wr    = wr;
        cur_dummy = wr ? 0 : dmy;
        if (wr) begin
            for (int i = 0; i < nb; i++) tx_mem[(tx_avail + i) % LOGN] = 8'($urandom);
            if (b0 >= 0) tx_mem[tx_avail % LOGN] = 8'(b0);
            if (b1 >= 0 && nb > 1) tx_mem[(tx_avail + 1) % LOGN] = 8'(b1);
            if (stall_at >= 0) stall_idx = tx_avail + stall_at;
            tx_avail = tx_avail + nb;
        end else begin
            rd_base = rd_base + 512;
            for (int i = 0; i < nb; i++) rd_mem[(rd_base + i) % LOGN] = 8'($urandom);
            if (b0 >= 0) rd_mem[rd_base % LOGN] = 8'(b0);
            if (b1 >= 0 && nb > 1) rd_mem[(rd_base + 1) % LOGN] = 8'(b1);
        end
    endtask

    task automatic xfer(input logic wr, input int len, input int dmy, input int b0, input int b1, input int stall_at);
        int nb, r0, q0, x0, o0, t0, exp_r, bad;
        logic [7:0] b;
        logic [3:0] nib;
        nb = len + 1;
        t0 = tx_avail;
        prep(wr, len, dmy, b0, b1, stall_at);
        #1;
        r0 = n_rise; q0 = n_qfall; x0 = n_rx; o0 = n_oe_bad;
        issue(wr, len, dmy);
        for (int c = 0; c < 20000 && busy; c++) @(negedge clk);
        #1;
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("idle_state", {29'd0, qss, cmd_ready, (qd_oe != 4'h0)}, {29'd0, 3'b110});
        exp_r = 2 * nb + (wr ? 0 : cur_dummy);
        chk("qck_rises", n_rise - r0, exp_r);
        chk("qss_windows", n_qfall - q0, 1);
        chk("oe_violations", n_oe_bad - o0, 0);
        if (wr) begin
            chk("rx_none", n_rx - x0, 0);
            for (int i = 0; i < 2 * nb; i++) begin
                b   = tx_mem[(t0 + i / 2) % LOGN];
                nib = i[0] ? b[3:0] : b[7:4];
                chk("wr_nibble", {24'd0, rise_log[(r0 + i) % LOGN]}, {24'd0, 4'hF, nib});
            end
        end else begin
            chk("rx_count", n_rx - x0, nb);
            for (int i = 0; i < nb; i++)
                chk("rx_byte", {24'd0, rx_log[(x0 + i) % LOGN]}, {24'd0, rd_mem[(rd_base + i) % LOGN]});
            bad = 0;
            for (int i = 1; i < exp_r; i++)
                if (rise_t[(r0 + i) % LOGN] - rise_t[(r0 + i - 1) % LOGN] != 2 * CLK_DIV) bad++;
            chk("qck_period", bad, 0);
            chk("first_edge_lat", rise_t[r0 % LOGN] - qfall_t, 2 * CLK_DIV);
        end
    endtask

    initial begin
        int r0, x0, s0, sb0, dmy;
        logic wr;
        #1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", {10'd0, rst_vec()}, {10'd0, RST_EXP});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        xfer(1'b1, 0, 0, 8'hA5, -1, -1);
        xfer(1'b0, 1, 0, 8'h3C, 8'h81, -1);

        #1;
        s0 = st_cyc; sb0 = st_bad;
        xfer(1'b1, 2, 0, -1, -1, 2);
        chk("stall_seen", {31'd0, (st_cyc - s0) > 0}, 32'd1);
        chk("stall_quiet", st_bad - sb0, 0);

        prep(1'b0, 3, 0, -1, -1, -1);
        #1;
        r0 = n_rise; x0 = n_rx;
        issue(1'b0, 3, 0);
        for (int c = 0; c < 2000 && (n_rise - r0) < 3; c++) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_async", {10'd0, rst_vec()}, {10'd0, RST_EXP});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("reset_rx_pulses", n_rx - x0, 1);
        chk("reset_idle", {31'd0, cmd_ready}, 32'd1);

        xfer(1'b0, 255, 0, -1, -1, -1);

`ifdef QSPI_MASTER_DUMMY_EN
        xfer(1'b0, 0, 4, -1, -1, -1);
        xfer(1'b1, 1, 3, -1, -1, -1);
`endif

        for (int k = 0; k < 24; k++) begin
            wr  = 1'($urandom);
            dmy = 0;
`ifdef QSPI_MASTER_DUMMY_EN
            dmy = int'($urandom_range(0, 5));
`endif
            xfer(wr, int'($urandom_range(0, 9)), dmy, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, limit %0d ns", 5000000);
        $fatal(1);
    end

endmodule
